rsa_uart_wrapper: RTL
=====================

# rsa_uart_wrapper

- Avalon-MM master that sits between the RS232 UART controller and the RSA-256 decryption core.
- Over the UART it receives a 32-byte modulus N, a 32-byte private key d, then an endless stream of 32-byte ciphertext blocks.
- For each block it starts the core, waits for completion, and writes the 31 low-order plaintext bytes back to the UART.
- The key (N, d) is loaded once per reset and reused for every following ciphertext block.

## Interface
Parameters:
- RX_BASE, 0: Avalon word address of the UART RX data register.
- TX_BASE, 1: Avalon word address of the UART TX data register.
- STATUS_BASE, 2: Avalon word address of the UART status register.
- RX_OK_BIT, 7: status bit meaning "RX byte available".
- TX_OK_BIT, 6: status bit meaning "TX ready for a byte".

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  read data; only [7:0] is used.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  write data, {24'b0, byte}.
- avm_waitrequest  in  1  slave stall; a transfer completes in a cycle where it is low.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a  out  256  ciphertext.
- o_core_d  out  256  private key.
- o_core_n  out  256  modulus.
- i_core_a_pow_d  in  256  plaintext result.
- i_core_finished  in  1  core done level; it falls in the cycle after the start pulse is sampled.
- o_key_loaded  out  1  high once N and d are stored.

## Operation
- Phases, tracked by a 2-bit phase register, in order: GET_N, GET_D, then GET_A forever. A byte counter (0..31) counts bytes within each phase.
- States and transitions:
  - S_QUERY_RX: read STATUS_BASE. On completion, go to S_READ if readdata[RX_OK_BIT] is 1, else re-issue the query.
  - S_READ: read RX_BASE. On completion, shift the byte into the phase's 256-bit register: reg <= {reg[247:0], readdata[7:0]}. Bytes arrive MSB first.
    - If the counter is 31: clear the counter and advance the phase. After GET_N go to S_QUERY_RX; after GET_D set o_key_loaded and go to S_QUERY_RX; after GET_A go to S_START.
    - Otherwise increment the counter and return to S_QUERY_RX.
  - S_START: o_core_start=1 for exactly one cycle, then S_WAIT.
  - S_WAIT: wait for i_core_finished=1. Then latch i_core_a_pow_d into the 256-bit TX shift register, clear the counter, and go to S_QUERY_TX.
  - S_QUERY_TX: read STATUS_BASE. On completion, go to S_SEND if readdata[TX_OK_BIT] is 1, else re-issue.
  - S_SEND: write TX_BASE with TX shift register bits [247:240].
    - On completion, shift the TX register left by 8.
    - If the counter is 30: clear the counter, return to S_QUERY_RX, and stay in phase GET_A (key kept).
    - Otherwise increment the counter and go to S_QUERY_TX.
- Output byte count and order: 31 bytes, from plaintext bits [247:240] down to [7:0]. Bits [255:248] are never sent.
- o_core_a/d/n are driven directly from the N, d and A registers. They are stable from S_START through S_WAIT.
- avm_read and avm_write are never high together.
- The ciphertext register is not modified while the core runs.

## Timing
- Reset values:
  - all outputs 0, except avm_address=STATUS_BASE;
  - state S_QUERY_RX, phase GET_N, counter 0;
  - N, d, A and TX registers all 0.
- Avalon request rules: avm_read or avm_write is asserted in the cycle the state is entered. Address and writedata are held constant while avm_waitrequest is high. The request drops in the cycle after it completes.
- Each poll or data access costs at least 2 cycles (request cycle plus one idle cycle) with zero wait states.
- Minimum per received byte: 4 cycles.
- Latency from completion of the 96th byte (last A byte) to o_core_start: 1 cycle.
- o_core_start is high for exactly 1 cycle per ciphertext block.
- i_core_finished is sampled only in S_WAIT, never in S_START.
- Reset asserted mid-transfer: the request drops asynchronously and the key is lost; after release the block restarts at GET_N.
- Status responses with the "not ready" bit clear are retried indefinitely; there is no timeout.

## Test plan
- Key plus one block: N=0xCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831, d=0x0000…0001, A=0x…0005. Expect 1 start pulse, o_core_n/d/a equal to the sent values, and 31 TX bytes equal to the model plaintext[247:0], MSB first.
- Back-to-back blocks: send 3 ciphertext blocks after one key. Expect 3 start pulses, o_key_loaded to stay 1, and N and d unchanged throughout.
- Wait states: avm_waitrequest random 0-5 cycles per transfer. Expect address and writedata stable during the stall, each byte consumed exactly once, and no duplicate TX bytes.
- Not-ready polling: RX_OK low for 50 status reads before each byte, and TX_OK low for 20 reads. Expect repeated STATUS_BASE reads only, and no RX read or TX write until the bit is set.
- Core handshake: the core model asserts i_core_finished after 1000 cycles. Expect no TX activity before then, and the first TX status poll 1-2 cycles later.
- Reset mid-GET_D after 10 bytes: pull i_rst_n low. Expect all outputs at reset values immediately, o_key_loaded=0, and the next 32 bytes after release loaded into N.

Source files
------------

// File: rtl/rsa_uart_if.sv
`timescale 1ns/1ps
// Avalon-MM link between the RSA wrapper (master side) and the RS232 UART controller (slave side).
interface rsa_uart_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (output avm_address, avm_read, avm_write, avm_writedata,
                    input  avm_readdata, avm_waitrequest);
    modport slave  (input  avm_address, avm_read, avm_write, avm_writedata,
                    output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/rsa_uart_wrapper.sv
`timescale 1ns/1ps
// Avalon-MM master that pulls N, d and ciphertext blocks from the UART, runs the
// RSA-256 core on each block and streams the 31 low-order plaintext bytes back out.
module rsa_uart_wrapper #(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd1,
    parameter logic [4:0] STATUS_BASE = 5'd2,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rsa_uart_if.master    bus,
    output logic          o_core_start,
    output logic [255:0]  o_core_a,
    output logic [255:0]  o_core_d,
    output logic [255:0]  o_core_n,
    input  logic [255:0]  i_core_a_pow_d,
    input  logic          i_core_finished,
    output logic          o_key_loaded
);

    typedef enum logic [2:0] {S_QUERY_RX, S_READ, S_START, S_WAIT, S_QUERY_TX, S_SEND} state_t;
    typedef enum logic [1:0] {GET_N, GET_D, GET_A} phase_t;

    state_t         r_state, w_state;
    state_t         r_ret, w_ret;
    phase_t         r_phase, w_phase;
    logic [4:0]     r_cnt, w_cnt;
    logic [255:0]   r_n, w_n, r_d, w_d, r_a, w_a;
    logic [247:0]   r_tx, w_tx;
    logic           r_read, w_read, r_write, w_write;
    logic [4:0]     r_addr, w_addr;
    logic           r_start, w_start;
    logic           r_key_loaded, w_key_loaded;
    logic [7:0]     w_byte;
    logic           w_unused;

    assign w_byte   = bus.avm_readdata[7:0];
    assign w_unused = &{1'b0, bus.avm_readdata[31:8], i_core_a_pow_d[255:248]};

    assign bus.avm_address   = r_addr;
    assign bus.avm_read      = r_read;
    assign bus.avm_write     = r_write;
    assign bus.avm_writedata = {24'h00_0000, r_tx[247:240]};
    assign o_core_start      = r_start;
    assign o_core_a          = r_a;
    assign o_core_d          = r_d;
    assign o_core_n          = r_n;
    assign o_key_loaded      = r_key_loaded;

    // State register and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_QUERY_RX;
            r_ret        <= S_QUERY_RX;
            r_phase      <= GET_N;
            r_cnt        <= 5'd0;
            r_n          <= 256'd0;
            r_d          <= 256'd0;
            r_a          <= 256'd0;
            r_tx         <= 248'd0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= STATUS_BASE;
            r_start      <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_ret        <= w_ret;
            r_phase      <= w_phase;
            r_cnt        <= w_cnt;
            r_n          <= w_n;
            r_d          <= w_d;
            r_a          <= w_a;
            r_tx         <= w_tx;
            r_read       <= w_read;
            r_write      <= w_write;
            r_addr       <= w_addr;
            r_start      <= w_start;
            r_key_loaded <= w_key_loaded;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state      = r_state;
        w_ret        = r_ret;
        w_phase      = r_phase;
        w_cnt        = r_cnt;
        w_n          = r_n;
        w_d          = r_d;
        w_a          = r_a;
        w_tx         = r_tx;
        w_read       = r_read;
        w_write      = r_write;
        w_addr       = r_addr;
        w_start      = 1'b0;
        w_key_loaded = r_key_loaded;
        case (r_state)
            S_QUERY_RX, S_READ, S_QUERY_TX, S_SEND: begin
                // With no request pending this is the idle cycle after a transfer:
                // move to the state chosen at completion and raise its request.
                if (!(r_read || r_write)) begin
                    w_state = r_ret;
                    case (r_ret)
                        S_READ:  begin w_read  = 1'b1; w_addr = RX_BASE;     end
                        S_SEND:  begin w_write = 1'b1; w_addr = TX_BASE;     end
                        default: begin w_read  = 1'b1; w_addr = STATUS_BASE; end
                    endcase
                end else if (bus.avm_waitrequest) begin
                    w_state = r_state;
                end else begin
                    w_read  = 1'b0;
                    w_write = 1'b0;
                    case (r_state)
                        S_QUERY_RX: w_ret = bus.avm_readdata[RX_OK_BIT] ? S_READ : S_QUERY_RX;
                        S_QUERY_TX: w_ret = bus.avm_readdata[TX_OK_BIT] ? S_SEND : S_QUERY_TX;
                        S_READ: begin
                            case (r_phase)
                                GET_N:   w_n = {r_n[247:0], w_byte};
                                GET_D:   w_d = {r_d[247:0], w_byte};
                                default: w_a = {r_a[247:0], w_byte};
                            endcase
                            if (r_cnt == 5'd31) begin
                                w_cnt = 5'd0;
                                case (r_phase)
                                    GET_N:   begin w_phase = GET_D; w_ret = S_QUERY_RX; end
                                    GET_D:   begin w_phase = GET_A; w_ret = S_QUERY_RX; w_key_loaded = 1'b1; end
                                    default: begin w_phase = GET_A; w_state = S_START; w_start = 1'b1; end
                                endcase
                            end else begin
                                w_cnt = r_cnt + 5'd1;
                                w_ret = S_QUERY_RX;
                            end
                        end
                        S_SEND: begin
                            w_tx = {r_tx[239:0], 8'h00};
                            if (r_cnt == 5'd30) begin
                                w_cnt = 5'd0;
                                w_ret = S_QUERY_RX;
                            end else begin
                                w_cnt = r_cnt + 5'd1;
                                w_ret = S_QUERY_TX;
                            end
                        end
                        default: w_ret = S_QUERY_RX;
                    endcase
                end
            end
            S_START: w_state = S_WAIT;
            S_WAIT: begin
                if (i_core_finished) begin
                    w_tx    = i_core_a_pow_d[247:0];
                    w_cnt   = 5'd0;
                    w_state = S_QUERY_TX;
                    w_read  = 1'b1;
                    w_addr  = STATUS_BASE;
                end else begin
                    w_state = S_WAIT;
                end
            end
            default: w_state = S_QUERY_RX;
        endcase
    end

endmodule
